// File: rtl/pc_ir_unit.sv
// pc_ir_unit: front-end register stage of the multicycle datapath.
// Holds PC, IR, ALUOut and MDR, and decodes the IR fields for the controller.
// Also keeps a fetched-instruction counter and a sticky misaligned-PC debug flag.
module pc_ir_unit #(
   parameter int                 DATA_W   = 32,
   parameter logic [DATA_W-1:0]  RESET_PC = '0,
   parameter int                 CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              PCWrite,
   input  logic              PCWriteCond,
   input  logic [1:0]        PCSource,
   input  logic              IRWrite,
   input  logic              Zero,
   input  logic [DATA_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] MemData,
   output logic [DATA_W-1:0] PC,
   output logic [DATA_W-1:0] IR,
   output logic [5:0]        Opcode,
   output logic [4:0]        Rs,
   output logic [4:0]        Rt,
   output logic [4:0]        Rd,
   output logic [DATA_W-1:0] Imm,
   output logic [DATA_W-1:0] ALUOut,
   output logic [DATA_W-1:0] MDR,
   output logic [CNT_W-1:0]  instr_count,
   output logic              misalign_err
);

   typedef enum logic [1:0] {
      SRC_ALU_RESULT = 2'b00,
      SRC_ALU_OUT    = 2'b01,
      SRC_JUMP       = 2'b10,
      SRC_RESERVED   = 2'b11
   } pc_src_e;

   logic [DATA_W-1:0] pc_target;
   logic              pc_load;
   logic              fetch;

   // Select the next-PC candidate and decide whether PC loads this cycle.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves it
      // unassigned and no latch is inferred.
      pc_target = PC;
      pc_load   = PCWrite | (PCWriteCond & Zero);
      unique case (pc_src_e'(PCSource))
         SRC_ALU_RESULT: pc_target = ALUResult;
         SRC_ALU_OUT:    pc_target = ALUOut;
         // Jump uses PC and IR as they stand before the edge.
         SRC_JUMP:       pc_target = {PC[DATA_W-1:28], IR[25:0], 2'b00};
         SRC_RESERVED:   pc_load   = 1'b0;
      endcase
   end

   // A fetch cycle is the only one that retires an instruction.
   assign fetch = IRWrite & PCWrite & (PCSource == SRC_ALU_RESULT);

   // PC register: loads the word-aligned target; misaligned loads set a sticky flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         PC           <= RESET_PC;
         misalign_err <= 1'b0;
      end else if (pc_load) begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values, which is what lets IR and PC update together.
         PC <= {pc_target[DATA_W-1:2], 2'b00};
         if (pc_target[1:0] != 2'b00)
            misalign_err <= 1'b1;
      end
   end

   // Instruction register: captures memory data when the controller strobes IRWrite.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         IR <= '0;
      else if (IRWrite)
         IR <= MemData;
   end

   // ALUOut and MDR are free-running one-cycle pipeline registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ALUOut <= '0;
         MDR    <= '0;
      end else begin
         ALUOut <= ALUResult;
         MDR    <= MemData;
      end
   end

   // Retired-instruction counter; wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         instr_count <= '0;
      else if (fetch)
         instr_count <= instr_count + 1'b1;
   end

   // Instruction field decode, straight from IR.
   assign Opcode = IR[31:26];
   assign Rs     = IR[25:21];
   assign Rt     = IR[20:16];
   assign Rd     = IR[15:11];
   assign Imm    = {{(DATA_W-16){IR[15]}}, IR[15:0]};

endmodule

// File: tb/tb_pc_ir_unit.sv
// Bench for pc_ir_unit: a spec-level model checked every cycle against two
// instances (default 16-bit counter and a 4-bit counter for wrap), plus
// hand-computed expectations for each directed scenario.
module tb_pc_ir_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        PCWrite = 1'b0;
   logic        PCWriteCond = 1'b0;
   logic [1:0]  PCSource = 2'b00;
   logic        IRWrite = 1'b0;
   logic        Zero = 1'b0;
   logic [31:0] ALUResult = '0;
   logic [31:0] MemData = '0;

   logic [31:0] PC, IR, Imm, ALUOut, MDR;
   logic [5:0]  Opcode;
   logic [4:0]  Rs, Rt, Rd;
   logic [15:0] instr_count;
   logic        misalign_err;

   logic [31:0] PC4, IR4, Imm4, ALUOut4, MDR4;
   logic [5:0]  Opcode4;
   logic [4:0]  Rs4, Rt4, Rd4;
   logic [3:0]  instr_count4;
   logic        misalign_err4;

   int n_total = 0;
   int n_pass  = 0;

   pc_ir_unit dut (
      .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .PCSource(PCSource), .IRWrite(IRWrite), .Zero(Zero), .ALUResult(ALUResult),
      .MemData(MemData), .PC(PC), .IR(IR), .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd),
      .Imm(Imm), .ALUOut(ALUOut), .MDR(MDR), .instr_count(instr_count),
      .misalign_err(misalign_err)
   );

   pc_ir_unit #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .PCSource(PCSource), .IRWrite(IRWrite), .Zero(Zero), .ALUResult(ALUResult),
      .MemData(MemData), .PC(PC4), .IR(IR4), .Opcode(Opcode4), .Rs(Rs4), .Rt(Rt4), .Rd(Rd4),
      .Imm(Imm4), .ALUOut(ALUOut4), .MDR(MDR4), .instr_count(instr_count4),
      .misalign_err(misalign_err4)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc, m_ir, m_aluout, m_mdr;
   int unsigned m_cnt;
   bit          m_err;

   function automatic void model_reset();
      m_pc = 32'h0; m_ir = 32'h0; m_aluout = 32'h0; m_mdr = 32'h0;
      m_cnt = 0; m_err = 1'b0;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         model_reset();
      end else begin
         bit          load;
         logic [31:0] tgt;
         load = PCWrite || (PCWriteCond && Zero);
         tgt  = 32'h0;
         case (PCSource)
            2'd0: tgt = ALUResult;
            2'd1: tgt = m_aluout;
            2'd2: tgt = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
            default: load = 1'b0;
         endcase
         if (IRWrite && PCWrite && PCSource == 2'd0)
            m_cnt = m_cnt + 1;
         if (load) begin
            if (tgt % 4 != 0) m_err = 1'b1;
            m_pc = tgt - (tgt % 4);
         end
         if (IRWrite) m_ir = MemData;
         m_aluout = ALUResult;
         m_mdr    = MemData;
      end
   end

   // Compare both instances to the model every cycle, away from the active edge.
   always @(negedge clk) begin
      logic [31:0] m_imm;
      m_imm = (m_ir & 32'h0000_8000) != 0 ? (m_ir | 32'hFFFF_0000) : (m_ir & 32'h0000_FFFF);
      check("PC",       PC,           m_pc);
      check("IR",       IR,           m_ir);
      check("Opcode",   {26'd0, Opcode}, m_ir / (1 << 26));
      check("Rs",       {27'd0, Rs},  (m_ir / (1 << 21)) % 32);
      check("Rt",       {27'd0, Rt},  (m_ir / (1 << 16)) % 32);
      check("Rd",       {27'd0, Rd},  (m_ir / (1 << 11)) % 32);
      check("Imm",      Imm,          m_imm);
      check("ALUOut",   ALUOut,       m_aluout);
      check("MDR",      MDR,          m_mdr);
      check("count16",  {16'd0, instr_count}, m_cnt % 65536);
      check("err",      {31'd0, misalign_err}, {31'd0, m_err});
      check("PC4",      PC4,          m_pc);
      check("IR4",      IR4,          m_ir);
      check("count4",   {28'd0, instr_count4}, m_cnt % 16);
      check("err4",     {31'd0, misalign_err4}, {31'd0, m_err});
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic pcw, input logic pcwc, input logic [1:0] src,
                        input logic irw, input logic z, input logic [31:0] alu,
                        input logic [31:0] mem);
      PCWrite = pcw; PCWriteCond = pcwc; PCSource = src;
      IRWrite = irw; Zero = z; ALUResult = alu; MemData = mem;
   endtask

   initial begin
      model_reset();
      #3;
      // Reset state
      check("rst PC",    PC, 32'h0);
      check("rst IR",    IR, 32'h0);
      check("rst count", {16'd0, instr_count}, 32'd0);
      check("rst err",   {31'd0, misalign_err}, 32'd0);
      repeat (2) step();
      reset = 1'b1;

      // T2 fetch: first put PC at 0x10, then fetch
      drive(1, 0, 2'b00, 0, 0, 32'h10, 32'h0);
      step();
      check("T2 PC setup", PC, 32'h10);
      drive(1, 0, 2'b00, 1, 0, 32'h14, 32'h8C22_0004);
      step();
      check("T2 PC",     PC, 32'h14);
      check("T2 IR",     IR, 32'h8C22_0004);
      check("T2 Opcode", {26'd0, Opcode}, 32'h23);
      check("T2 Rs",     {27'd0, Rs}, 32'd1);
      check("T2 Rt",     {27'd0, Rt}, 32'd2);
      check("T2 Imm",    Imm, 32'h4);
      check("T2 count",  {16'd0, instr_count}, 32'd1);

      // T3 branch: ALUOut=0x40, Zero=0 holds, Zero=1 loads
      drive(0, 0, 2'b00, 0, 0, 32'h40, 32'h0);
      step();
      check("T3 ALUOut", ALUOut, 32'h40);
      drive(0, 1, 2'b01, 0, 0, 32'h40, 32'h0);
      step();
      check("T3 hold PC", PC, 32'h14);
      drive(0, 1, 2'b01, 0, 1, 32'h40, 32'h0);
      step();
      check("T3 taken PC", PC, 32'h40);
      check("T3 err", {31'd0, misalign_err}, 32'd0);

      // T4 jump: PCWrite|PCWriteCond with Zero=0 still loads
      drive(1, 1, 2'b00, 0, 0, 32'h1000_0008, 32'h0);
      step();
      check("T4 PC setup", PC, 32'h1000_0008);
      drive(0, 0, 2'b00, 1, 0, 32'h0, 32'h0800_0123);
      step();
      check("T4 IR", IR, 32'h0800_0123);
      // Jump with IRWrite: target uses pre-edge IR, count must not move
      drive(1, 0, 2'b10, 1, 0, 32'h0, 32'hFFFF_FFFF);
      step();
      check("T4 PC",    PC, 32'h1000_048C);
      check("T4 Imm",   Imm, 32'hFFFF_FFFF);
      check("T4 count", {16'd0, instr_count}, 32'd1);
      // Reserved source: no load, no flag even with a misaligned ALUResult
      drive(1, 0, 2'b11, 0, 0, 32'h3, 32'h0);
      step();
      check("rsv PC",  PC, 32'h1000_048C);
      check("rsv err", {31'd0, misalign_err}, 32'd0);

      // T5 misalign
      drive(1, 0, 2'b00, 0, 0, 32'h102, 32'h0);
      step();
      check("T5 PC",  PC, 32'h100);
      check("T5 err", {31'd0, misalign_err}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 2'b00, 0, 0, 32'h104 + 32'(4 * i), 32'h0);
         step();
      end
      check("T5 PC after", PC, 32'h128);
      check("T5 err sticky", {31'd0, misalign_err}, 32'd1);

      // T1 async reset mid-cycle with PCWrite=1
      drive(1, 0, 2'b00, 1, 0, 32'h200, 32'h1234_5678);
      #2 reset = 1'b0;
      #1;
      check("T1 PC",    PC, 32'h0);
      check("T1 IR",    IR, 32'h0);
      check("T1 count", {16'd0, instr_count}, 32'd0);
      check("T1 err",   {31'd0, misalign_err}, 32'd0);
      step();
      check("T1 held PC", PC, 32'h0);
      reset = 1'b1;

      // T6 counter wrap on the 4-bit instance
      for (int i = 0; i < 16; i++) begin
         drive(1, 0, 2'b00, 1, 0, 32'(4 * (i + 1)), 32'h0000_0010);
         step();
         if (i == 14) check("T6 count4 15", {28'd0, instr_count4}, 32'd15);
      end
      check("T6 count4 wrap", {28'd0, instr_count4}, 32'd0);
      check("T6 count16",     {16'd0, instr_count}, 32'd16);
      drive(1, 0, 2'b10, 1, 0, 32'h0, 32'h0);
      step();
      check("T6 jump no inc", {16'd0, instr_count}, 32'd16);
      drive(0, 0, 2'b00, 0, 0, 32'h0, 32'h0);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
